// File: rtl/uart_tx_ctrl_if.sv
// Handshake bundle between the UART_TX frame controller and its neighbours.
// Latency: n/a (wires only).
// Backpressure: none. Data_Valid is only honoured while BUSY is low.
//
// Signals:
//   Data_Valid  master->slave  new frame request, P_DATA valid this cycle
//   PAR_EN      master->slave  parity enable, sampled at frame accept
//   Ser_Done    master->slave  serializer presenting its last data bit
//   Ser_Enable  slave->master  serializer shift/count enable
//   Mux_Sel     slave->master  00=start 01=stop/idle 10=Ser_Data 11=parity
//   BUSY        slave->master  frame in progress (registered)
//   Frame_Done  slave->master  pulse in the final stop-bit cycle
interface uart_tx_ctrl_if;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       Ser_Done;
    logic       Ser_Enable;
    logic [1:0] Mux_Sel;
    logic       BUSY;
    logic       Frame_Done;

    modport master (
        output Data_Valid, PAR_EN, Ser_Done,
        input  Ser_Enable, Mux_Sel, BUSY, Frame_Done
    );

    modport slave (
        input  Data_Valid, PAR_EN, Ser_Done,
        output Ser_Enable, Mux_Sel, BUSY, Frame_Done
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// Moore FSM sequencing one UART_TX frame: start, data, optional parity, stop bits.
// Latency: START one cycle after Data_Valid accept; frame = 1+DATA_WIDTH+parity+STOP_BITS cycles.
// Backpressure: Data_Valid is ignored while BUSY=1; at least one IDLE cycle between frames.
//
// Ports:
//   CLK  clock
//   RST  asynchronous, active-low reset
//   bus  uart_tx_ctrl_if.slave (Data_Valid, PAR_EN, Ser_Done in;
//        Ser_Enable, Mux_Sel, BUSY, Frame_Done out)
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic            CLK,
    input  logic            RST,
    uart_tx_ctrl_if.slave   bus
);

    // Serial bit count is owned by the serializer; DATA_WIDTH only documents
    // the pairing with it.
    localparam int DW_UNUSED = DATA_WIDTH;

    localparam logic [1:0] MUX_START  = 2'b00;
    localparam logic [1:0] MUX_STOP   = 2'b01;
    localparam logic [1:0] MUX_DATA   = 2'b10;
    localparam logic [1:0] MUX_PARITY = 2'b11;

    localparam logic [1:0] STOP_LAST = 2'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic       par_en_q, par_en_d;
    logic [1:0] stop_cnt_q, stop_cnt_d;
    logic       busy_q, busy_d;

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            par_en_q   <= 1'b0;
            stop_cnt_q <= 2'd0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            par_en_q   <= par_en_d;
            stop_cnt_q <= stop_cnt_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        par_en_d   = par_en_q;
        stop_cnt_d = 2'd0;
        case (state_q)
            S_IDLE: begin
                // The serializer loads P_DATA on this same edge since BUSY=0.
                if (bus.Data_Valid) begin
                    state_d  = S_START;
                    par_en_d = bus.PAR_EN;
                end
            end
            S_START: state_d = S_DATA;
            S_DATA: begin
                if (bus.Ser_Done) begin
                    state_d = par_en_q ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: state_d = S_STOP;
            S_STOP: begin
                // Counter is zero on entry and returns to zero on exit.
                if (stop_cnt_q == STOP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    stop_cnt_d = stop_cnt_q + 2'd1;
                end
            end
            default: state_d = S_IDLE;  // illegal encodings recover
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // Moore output decode: no input-to-output paths.
    always_comb begin
        bus.Ser_Enable = 1'b0;
        bus.Mux_Sel    = MUX_STOP;
        bus.Frame_Done = 1'b0;
        case (state_q)
            S_START:  bus.Mux_Sel = MUX_START;
            S_DATA: begin
                bus.Ser_Enable = 1'b1;
                bus.Mux_Sel    = MUX_DATA;
            end
            S_PARITY: bus.Mux_Sel = MUX_PARITY;
            S_STOP:   bus.Frame_Done = (stop_cnt_q == STOP_LAST);
            default: ;
        endcase
    end

    assign bus.BUSY = busy_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;

    localparam int W = 8;

    localparam int ST_IDLE   = 0;
    localparam int ST_START  = 1;
    localparam int ST_DATA   = 2;
    localparam int ST_PARITY = 3;
    localparam int ST_STOP   = 4;

    logic CLK;
    logic RST;
    int   vectors;
    int   miscompares;

    uart_tx_ctrl_if if1 ();
    uart_tx_ctrl_if if2 ();

    uart_tx_ctrl #(.DATA_WIDTH(W), .STOP_BITS(1)) dut1 (.CLK(CLK), .RST(RST), .bus(if1.slave));
    uart_tx_ctrl #(.DATA_WIDTH(W), .STOP_BITS(2)) dut2 (.CLK(CLK), .RST(RST), .bus(if2.slave));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Serializer stand-ins: count enabled cycles, flag the W-th one.
    int cnt1, cnt2;
    always @(posedge CLK or negedge RST) begin
        if (!RST) cnt1 <= 0;
        else if (if1.Ser_Enable) cnt1 <= (cnt1 == W - 1) ? 0 : cnt1 + 1;
    end
    always @(posedge CLK or negedge RST) begin
        if (!RST) cnt2 <= 0;
        else if (if2.Ser_Enable) cnt2 <= (cnt2 == W - 1) ? 0 : cnt2 + 1;
    end
    assign if1.Ser_Done = if1.Ser_Enable && (cnt1 == W - 1);
    assign if2.Ser_Done = if2.Ser_Enable && (cnt2 == W - 1);

    logic dv1, dv2, par_en;
    assign if1.Data_Valid = dv1;
    assign if2.Data_Valid = dv2;
    assign if1.PAR_EN     = par_en;
    assign if2.PAR_EN     = par_en;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input bit d2, input int st, input logic efd, input string tag);
        logic [1:0] m, emux;
        logic       b, e, f, ebusy, een;
        m = d2 ? if2.Mux_Sel    : if1.Mux_Sel;
        b = d2 ? if2.BUSY       : if1.BUSY;
        e = d2 ? if2.Ser_Enable : if1.Ser_Enable;
        f = d2 ? if2.Frame_Done : if1.Frame_Done;
        case (st)
            ST_START:  begin emux = 2'b00; ebusy = 1'b1; een = 1'b0; end
            ST_DATA:   begin emux = 2'b10; ebusy = 1'b1; een = 1'b1; end
            ST_PARITY: begin emux = 2'b11; ebusy = 1'b1; een = 1'b0; end
            ST_STOP:   begin emux = 2'b01; ebusy = 1'b1; een = 1'b0; end
            default:   begin emux = 2'b01; ebusy = 1'b0; een = 1'b0; end
        endcase
        vectors++;
        assert (m === emux) else begin
            miscompares++;
            $error("FAIL %s Mux_Sel observed %b expected %b", tag, m, emux);
        end
        vectors++;
        assert (b === ebusy) else begin
            miscompares++;
            $error("FAIL %s BUSY observed %b expected %b", tag, b, ebusy);
        end
        vectors++;
        assert (e === een) else begin
            miscompares++;
            $error("FAIL %s Ser_Enable observed %b expected %b", tag, e, een);
        end
        vectors++;
        assert (f === efd) else begin
            miscompares++;
            $error("FAIL %s Frame_Done observed %b expected %b", tag, f, efd);
        end
    endtask

    // Entered in cycle c0 (IDLE, Data_Valid asserted); returns in the IDLE
    // cycle that follows the last stop bit.
    task automatic frame(input bit d2, input bit par, input int stops, input bit hold, input string tag);
        chk(d2, ST_IDLE, 1'b0, {tag, "_c0"});
        step();
        if (!hold) begin dv1 = 1'b0; dv2 = 1'b0; end
        chk(d2, ST_START, 1'b0, {tag, "_start"});
        for (int i = 0; i < W; i++) begin
            step();
            chk(d2, ST_DATA, 1'b0, {tag, "_data"});
        end
        if (par) begin
            step();
            chk(d2, ST_PARITY, 1'b0, {tag, "_parity"});
        end
        for (int s = 0; s < stops; s++) begin
            step();
            chk(d2, ST_STOP, (s == stops - 1), {tag, "_stop"});
        end
        step();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        RST    = 1'b0;
        dv1    = 1'b0;
        dv2    = 1'b0;
        par_en = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk(1'b0, ST_IDLE, 1'b0, "reset1");
        chk(1'b1, ST_IDLE, 1'b0, "reset2");
        RST = 1'b1;
        step();
        chk(1'b0, ST_IDLE, 1'b0, "idle_after_reset");

        // T1: no parity, one stop bit.
        dv1 = 1'b1; par_en = 1'b0;
        frame(1'b0, 1'b0, 1, 1'b0, "t1");
        chk(1'b0, ST_IDLE, 1'b0, "t1_idle_c11");
        step();

        // T2: parity enabled.
        dv1 = 1'b1; par_en = 1'b1;
        frame(1'b0, 1'b1, 1, 1'b0, "t2");
        chk(1'b0, ST_IDLE, 1'b0, "t2_idle_c12");
        step();

        // T3: two stop bits with parity on the second instance.
        dv2 = 1'b1; par_en = 1'b1;
        frame(1'b1, 1'b1, 2, 1'b0, "t3");
        chk(1'b1, ST_IDLE, 1'b0, "t3_idle_c13");
        step();

        // T4: PAR_EN drops mid-frame, Data_Valid pulse mid-frame.
        dv1 = 1'b1; par_en = 1'b1;
        chk(1'b0, ST_IDLE, 1'b0, "t4_c0");
        step(); dv1 = 1'b0;
        chk(1'b0, ST_START, 1'b0, "t4_c1");
        step();
        chk(1'b0, ST_DATA, 1'b0, "t4_c2");
        step(); par_en = 1'b0;
        chk(1'b0, ST_DATA, 1'b0, "t4_c3");
        step();
        chk(1'b0, ST_DATA, 1'b0, "t4_c4");
        step(); dv1 = 1'b1;
        chk(1'b0, ST_DATA, 1'b0, "t4_c5");
        for (int c = 6; c <= 9; c++) begin
            step(); dv1 = 1'b0;
            chk(1'b0, ST_DATA, 1'b0, "t4_data");
        end
        step();
        chk(1'b0, ST_PARITY, 1'b0, "t4_c10");
        step();
        chk(1'b0, ST_STOP, 1'b1, "t4_c11");
        step();
        chk(1'b0, ST_IDLE, 1'b0, "t4_c12");
        step();
        chk(1'b0, ST_IDLE, 1'b0, "t4_c13");
        step();

        // T5: Data_Valid held high across three frames.
        dv1 = 1'b1; par_en = 1'b0;
        frame(1'b0, 1'b0, 1, 1'b1, "t5f1");
        frame(1'b0, 1'b0, 1, 1'b1, "t5f2");
        frame(1'b0, 1'b0, 1, 1'b0, "t5f3");
        chk(1'b0, ST_IDLE, 1'b0, "t5_idle_c33");
        step();
        chk(1'b0, ST_IDLE, 1'b0, "t5_idle_c34");

        // T6: reset pulse mid-DATA.
        dv1 = 1'b1; par_en = 1'b0;
        chk(1'b0, ST_IDLE, 1'b0, "t6_c0");
        step(); dv1 = 1'b0;
        chk(1'b0, ST_START, 1'b0, "t6_c1");
        for (int c = 2; c <= 6; c++) begin
            step();
            chk(1'b0, ST_DATA, 1'b0, "t6_data");
        end
        RST = 1'b0;
        #1;
        chk(1'b0, ST_IDLE, 1'b0, "t6_rst_immediate");
        step();
        RST = 1'b1;
        chk(1'b0, ST_IDLE, 1'b0, "t6_c7_released");
        step();
        chk(1'b0, ST_IDLE, 1'b0, "t6_c8_idle");
        dv1 = 1'b1;
        frame(1'b0, 1'b0, 1, 1'b0, "t6_new");
        chk(1'b0, ST_IDLE, 1'b0, "t6_new_idle");
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
